// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch-side logic.
package mips_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_DROP
   } state_t;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_EXC,
      SRC_BRANCH,
      SRC_JR,
      SRC_JUMP
   } redir_src_t;

endpackage

// File: rtl/next_pc_mux.sv
// Redirect priority select: exception > branch > register jump > J-type jump.
// Forms the J-type target and word-aligns register-jump targets.
module next_pc_mux
   import mips_pkg::*;
(
   input  logic        exc_en_i,
   input  logic        branch_en_i,
   input  logic [31:0] branch_target_i,
   input  logic        jr_en_i,
   input  logic [31:0] jr_target_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_pc_i,
   input  logic [25:0] jump_index_i,
   output redir_src_t  src_o,
   output logic [31:0] target_o,
   output logic        misalign_o
);

   logic [31:0] jp4;
   logic        unused_jp4_lo;

   // Only the upper nibble of the jump's PC+4 feeds the J-type target.
   assign jp4           = jump_pc_i + 32'd4;
   assign unused_jp4_lo = ^jp4[27:0];

   // Highest-priority active redirect wins; EX-stage sources beat ID-stage jumps.
   always_comb begin
      src_o      = SRC_NONE;
      target_o   = 32'h0000_0000;
      misalign_o = 1'b0;
      if (exc_en_i) begin
         src_o    = SRC_EXC;
         target_o = EXC_VECTOR;
      end else if (branch_en_i) begin
         src_o    = SRC_BRANCH;
         target_o = branch_target_i;
      end else if (jr_en_i) begin
         src_o      = SRC_JR;
         target_o   = {jr_target_i[31:2], 2'b00};
         misalign_o = |jr_target_i[1:0];
      end else if (jump_en_i) begin
         src_o    = SRC_JUMP;
         target_o = {jp4[31:28], jump_index_i, 2'b00};
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, issues instruction-memory requests, hands
// fetched instructions to decode and discards responses made stale by a redirect.
module pc_sequencer
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   input  logic        jump_en,
   input  logic [31:0] jump_pc,
   input  logic [25:0] jump_index,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   input  logic        exc_en,
   output logic        addr_err
);

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        err_q, err_d;

   redir_src_t  src;
   logic [31:0] target;
   logic        misalign;
   logic        redir;

   next_pc_mux u_next_pc_mux (
      .exc_en_i        (exc_en),
      .branch_en_i     (branch_en),
      .branch_target_i (branch_target),
      .jr_en_i         (jr_en),
      .jr_target_i     (jr_target),
      .jump_en_i       (jump_en),
      .jump_pc_i       (jump_pc),
      .jump_index_i    (jump_index),
      .src_o           (src),
      .target_o        (target),
      .misalign_o      (misalign)
   );

   assign redir = (src != SRC_NONE);

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_VECTOR;
         valid_q <= 1'b0;
         instr_q <= 32'h0000_0000;
         pc_q    <= 32'h0000_0000;
         tgt_q   <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: fetch, hold for decode, or drain a stale request.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = RESET_VECTOR;
         end
         S_REQ: begin
            if (imem_ack && !redir) begin
               instr_d = imem_rdata;
               pc_d    = addr_q;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = S_HOLD;
            end else if (imem_ack && redir) begin
               addr_d = target;
               err_d  = misalign;
            end else if (redir) begin
               tgt_d   = target;
               err_d   = misalign;
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            // A redirect outranks if_ready; the held instruction counts as consumed.
            if (redir) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = target;
               err_d   = misalign;
               state_d = S_REQ;
            end else if (if_ready) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = addr_q + 32'd4;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (redir) begin
               tgt_d = target;
               err_d = misalign;
            end
            if (imem_ack) begin
               addr_d  = redir ? target : tgt_q;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_valid  = valid_q;
   assign if_instr  = instr_q;
   assign if_pc     = pc_q;
   assign addr_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        jump_en;
   logic [31:0] jump_pc;
   logic [25:0] jump_index;
   logic        branch_en;
   logic [31:0] branch_target;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        exc_en;
   logic        addr_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: what the fetch unit is doing, expressed as flags.
   bit          m_started, m_req, m_valid, m_stale, m_err;
   logic [31:0] m_addr, m_instr, m_pc, m_pend;
   logic [31:0] salt;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_ready      (if_ready),
      .jump_en       (jump_en),
      .jump_pc       (jump_pc),
      .jump_index    (jump_index),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .jr_en         (jr_en),
      .jr_target     (jr_target),
      .exc_en        (exc_en),
      .addr_err      (addr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_req", 32'(imem_req), 32'(m_req));
      chk("imem_addr", imem_addr, m_addr);
      chk("if_valid", 32'(if_valid), 32'(m_valid));
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_pc);
      chk("addr_err", 32'(addr_err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_started = 0; m_req = 0; m_valid = 0; m_stale = 0; m_err = 0;
      m_addr = 32'h0; m_instr = 32'h0; m_pc = 32'h0; m_pend = 32'h0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit          rd, mis;
      logic [31:0] t, jp4;
      rd  = exc_en | branch_en | jr_en | jump_en;
      mis = 0;
      t   = 32'h0;
      jp4 = jump_pc + 32'd4;
      if (exc_en) t = 32'h8000_0180;
      else if (branch_en) t = branch_target;
      else if (jr_en) begin
         t   = jr_target - (jr_target % 32'd4);
         mis = (jr_target % 32'd4) != 0;
      end else if (jump_en) t = (jp4 - (jp4 % 32'h1000_0000)) + 32'(jump_index) * 32'd4;
      m_err = 0;
      if (!m_started) begin
         m_started = 1; m_req = 1; m_addr = 32'h0;
      end else if (m_valid) begin
         if (rd) begin
            m_valid = 0; m_req = 1; m_addr = t; m_err = mis;
         end else if (if_ready) begin
            m_valid = 0; m_req = 1; m_addr = m_addr + 32'd4;
         end
      end else if (m_stale) begin
         if (rd) begin
            m_pend = t; m_err = mis;
         end
         if (imem_ack) begin
            m_stale = 0; m_addr = m_pend;
         end
      end else begin
         if (imem_ack && !rd) begin
            m_valid = 1; m_req = 0; m_instr = imem_rdata; m_pc = m_addr;
         end else if (rd) begin
            m_err = mis;
            if (imem_ack) m_addr = t;
            else begin
               m_stale = 1; m_pend = t;
            end
         end
      end
   endtask

   task automatic tick();
      imem_rdata = mem(m_addr);
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic clear_redirects();
      jump_en = 0; branch_en = 0; jr_en = 0; exc_en = 0;
   endtask

   task automatic go_hold();
      if_ready = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid) break;
         imem_ack = m_req;
         tick();
      end
      imem_ack = 0;
      chk("reach_hold", 32'(if_valid), 32'd1);
   endtask

   initial begin
      logic [5:0]  vpat;
      logic [31:0] alog [$];

      reset = 1; imem_ack = 0; imem_rdata = 0; if_ready = 0;
      jump_pc = 0; jump_index = 0; branch_target = 0; jr_target = 0;
      clear_redirects();
      salt = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 0;

      // Back-to-back fetch with 1-cycle ack, decode always ready, rdata = address.
      if_ready = 1;
      vpat = 6'b0;
      for (int i = 0; i < 6; i++) begin
         imem_ack = m_req;
         tick();
         vpat = {vpat[4:0], if_valid};
         if (imem_req) alog.push_back(imem_addr);
      end
      imem_ack = 0;
      chk("seq_count", 32'(alog.size()), 32'd3);
      if (alog.size() == 3) begin
         chk("seq_addr0", alog[0], 32'h0);
         chk("seq_addr1", alog[1], 32'h4);
         chk("seq_addr2", alog[2], 32'h8);
      end
      chk("valid_period", 32'(vpat), 32'(6'b010101));
      chk("seq_pc", if_pc, 32'h8);
      chk("seq_instr", if_instr, 32'h8);

      salt = 32'hC0DE_0000;

      // J-type jump across a 256 MB region boundary.
      go_hold();
      jump_en = 1; jump_pc = 32'h0FFF_FFFC; jump_index = 26'h0000010;
      tick();
      clear_redirects();
      chk("jump_addr", imem_addr, 32'h1000_0040);

      // Branch while the current request is outstanding: the stale ack is dropped.
      imem_ack = 0;
      tick();
      branch_en = 1; branch_target = 32'h0040_0100;
      tick();
      clear_redirects();
      tick();
      imem_ack = 1;
      tick();
      chk("drop_valid", 32'(if_valid), 32'd0);
      chk("drop_addr", imem_addr, 32'h0040_0100);
      chk("drop_req", 32'(imem_req), 32'd1);
      tick();
      imem_ack = 0;
      chk("drop_new_pc", if_pc, 32'h0040_0100);
      chk("drop_new_instr", if_instr, 32'h0040_0100 ^ 32'hC0DE_0000);

      // Simultaneous redirects: exception wins, then branch over jump.
      go_hold();
      exc_en = 1; branch_en = 1; branch_target = 32'h0000_0100; jump_en = 1;
      jump_pc = 32'h0000_2000; jump_index = 26'h0000123;
      tick();
      clear_redirects();
      chk("prio_exc", imem_addr, 32'h8000_0180);
      go_hold();
      branch_en = 1; branch_target = 32'h0000_0100; jump_en = 1;
      tick();
      clear_redirects();
      chk("prio_branch", imem_addr, 32'h0000_0100);

      // Misaligned register jump is aligned and flagged for one cycle.
      go_hold();
      jr_en = 1; jr_target = 32'h0040_0007;
      tick();
      clear_redirects();
      chk("jr_addr", imem_addr, 32'h0040_0004);
      chk("jr_err_pulse", 32'(addr_err), 32'd1);
      tick();
      chk("jr_err_clear", 32'(addr_err), 32'd0);

      // Reset with a request outstanding; the late ack must be ignored.
      chk("pre_reset_req", 32'(imem_req), 32'd1);
      reset = 1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset = 0;
      imem_ack = 1;
      tick();
      imem_ack = 0;
      chk("rst_first_req", 32'(imem_req), 32'd1);
      chk("rst_first_addr", imem_addr, 32'h0);
      tick();
      chk("rst_ack_ignored", 32'(if_valid), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if_ready      = ($urandom % 2) == 0;
         imem_ack      = m_req && (($urandom % 3) != 0);
         exc_en        = ($urandom % 20) == 0;
         branch_en     = ($urandom % 10) == 0;
         jr_en         = ($urandom % 10) == 0;
         jump_en       = ($urandom % 10) == 0;
         branch_target = $urandom & 32'hFFFF_FFFC;
         jr_target     = $urandom;
         jump_pc       = $urandom & 32'hFFFF_FFFC;
         jump_index    = 26'($urandom);
         tick();
      end
      clear_redirects();
      imem_ack = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller of the MIPS datapath. It owns the program counter, issues instruction-memory requests and presents fetched instructions to the decode stage under a valid/ready handshake. It selects the next PC among sequential, branch, register-jump, J-type jump and exception-vector targets, and forms the J-type target from the jump's PC+4 upper nibble and its 26-bit index. It discards in-flight fetches that a redirect makes stale.

## Interface
- Reset is asynchronous, active-high; one clock.
- RESET_VECTOR, 32'h0000_0000: PC loaded at reset.
- EXC_VECTOR, 32'h8000_0180: exception entry PC.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held with imem_addr stable until imem_ack.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  request complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  if_instr/if_pc valid for decode.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_ready  in  1  decode accepts if_instr this cycle.
- jump_en  in  1  J/JAL decoded in ID.
- jump_pc  in  32  PC of the jump instruction.
- jump_index  in  26  instr[25:0] of the jump.
- branch_en  in  1  taken branch resolved in EX.
- branch_target  in  32  branch destination.
- jr_en  in  1  JR/JALR resolved in EX.
- jr_target  in  32  register destination.
- exc_en  in  1  exception raised.
- addr_err  out  1  one-cycle pulse: misaligned jr_target was accepted.

## Operation
- Redirect priority: exc_en > branch_en > jr_en > jump_en. EX-stage redirects beat ID-stage redirects.
- Jump target: {jp4[31:28], jump_index, 2'b00}, where jp4 = jump_pc + 32'd4 (mod 2^32).
- jr_target[1:0] != 0: the target is forced to {jr_target[31:2], 2'b00} and addr_err pulses.
- Sequential next PC is imem_addr + 4, wrapping modulo 2^32.
- State S_IDLE: entered only from reset. Next state is S_REQ.
- State S_REQ: imem_req=1, if_valid=0.
  - ack with no redirect: capture rdata/addr into the if_* registers, set fetch_pc = addr + 4, go to S_HOLD.
  - ack with a redirect: drop rdata, fetch_pc = target, stay in S_REQ and issue the new address next cycle.
  - redirect without ack: latch the target, go to S_DROP.
- State S_HOLD: imem_req=0, if_valid=1.
  - if_ready: go to S_REQ with fetch_pc.
  - redirect: clear if_valid, go to S_REQ at the target. This applies even if if_ready is high the same cycle; the instruction is treated as consumed.
- State S_DROP: imem_req stays high on the stale address until ack.
  - On ack, discard rdata and go to S_REQ at the latched target.
  - A newer redirect while in S_DROP overwrites the latched target, priority applied.
- The stale response is never presented to decode.

## Timing
- All outputs are registered.
- Reset values: imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, addr_err=0, state S_IDLE.
- imem_req first rises 1 cycle after reset deasserts, with addr RESET_VECTOR.
- Ack at cycle t: if_valid=1 at t+1.
- if_ready at t: next imem_req at t+1.
- Sustained throughput is one instruction per L+1 cycles, where L is memory ack latency (L ≥ 1).
- Redirect observed at t: new address on imem_addr at t+1, unless an outstanding request forces the S_DROP wait.
- Reset mid-request: everything returns to reset values immediately. A later imem_ack for the abandoned request is ignored in S_IDLE.

## Structure
- Shared package mips_pkg holds:
  - the state enum (S_IDLE, S_REQ, S_HOLD, S_DROP);
  - the redirect-source enum;
  - default RESET_VECTOR and EXC_VECTOR constants.
- One combinational sub-module, next_pc_mux, holds the priority select, jump concatenation and jr alignment/addr_err detect. The FSM and registers live in pc_sequencer.

## Test plan
- Reset release, 1-cycle ack, if_ready tied high, rdata = address: imem_addr sequence 0x0,0x4,0x8. if_pc matches. if_valid period = 2 cycles.
- jump_en in S_HOLD, jump_pc=0x0FFF_FFFC, jump_index=0x0000010: next imem_addr = 0x1000_0040.
- In S_REQ, ack withheld 3 cycles; branch_en, branch_target=0x0040_0100: enters S_DROP, stale ack data never appears on if_*, next imem_addr = 0x0040_0100.
- Same cycle: exc_en, branch_en (0x100), jump_en: target 0x8000_0180. Without exc_en: target 0x100.
- jr_en, jr_target=0x0040_0007: imem_addr = 0x0040_0004, addr_err high for exactly one cycle.
- reset asserted with a request outstanding, then an ack arrives after release: outputs at reset values, ack ignored, first request at RESET_VECTOR.
